// File: rtl/dadda_mul_arbiter_if.sv
// Request/response bundle between NREQ multiply clients and dadda_mul_arbiter.
//   req_valid/req_a/req_b : per-requester operand pairs (master -> slave)
//   req_ready             : one-hot accept strobe (slave -> master)
//   resp_valid/resp_ready : product handshake; resp_id tags the owner, resp_y = a*b
//   busy                  : arbiter is not idle
interface dadda_mul_arbiter_if #(parameter int NREQ = 4);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_a;
  logic [NREQ-1:0][7:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [15:0]          resp_y;
  logic                 busy;

  modport master (output req_valid, req_a, req_b, resp_ready,
                  input  req_ready, resp_valid, resp_id, resp_y, busy);
  modport slave  (input  req_valid, req_a, req_b, resp_ready,
                  output req_ready, resp_valid, resp_id, resp_y, busy);
endinterface

// File: rtl/dadda_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 8x8 Dadda multiplier among NREQ
// requesters. FSM IDLE -> MUL -> HOLD -> IDLE; operands are registered on accept,
// the product is registered into the response port and held until resp_ready.
// Ports: clk, rst_n (async, active low), bus (dadda_mul_arbiter_if.slave).
// Optional feature macro: MUL_ARB_BYPASS_EN -- on the HOLD handshake a pending
// request is granted directly (HOLD -> MUL), giving a 2-cycle issue interval.

// Unsigned 8x8 Dadda multiplier. Partial-product bit matrix is reduced column by
// column to the Dadda heights 6,4,3,2 (half adder when one over target, full adder
// otherwise), then the final two rows are summed.
module dadda_8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] y_o
);
  logic [15:0] row0, row1;

  always_comb begin
    logic [15:0][15:0] m, nm;   // [column][bit within column]
    int h [16];
    int nh [16];
    int k, d;
    logic s, cy;
    m = '0; nm = '0; k = 0; d = 0; s = 1'b0; cy = 1'b0;
    row0 = '0; row1 = '0;
    for (int c = 0; c < 16; c++) begin
      h[4'(c)] = 0;
      nh[4'(c)] = 0;
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        m[4'(i+j)][4'(h[4'(i+j)])] = a_i[3'(i)] & b_i[3'(j)];
        h[4'(i+j)] = h[4'(i+j)] + 1;
      end
    for (int st = 0; st < 4; st++) begin
      d = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
      nm = '0;
      for (int c = 0; c < 16; c++) nh[4'(c)] = 0;
      for (int c = 0; c < 16; c++) begin
        k = 0;
        // nh[c] already holds carries from column c-1 of this stage
        for (int r = 0; r < 8; r++) begin
          if (h[4'(c)] - k + nh[4'(c)] > d) begin
            if (h[4'(c)] - k + nh[4'(c)] == d + 1) begin
              s  = m[4'(c)][4'(k)] ^ m[4'(c)][4'(k+1)];
              cy = m[4'(c)][4'(k)] & m[4'(c)][4'(k+1)];
              k  = k + 2;
            end else begin
              s  = m[4'(c)][4'(k)] ^ m[4'(c)][4'(k+1)] ^ m[4'(c)][4'(k+2)];
              cy = (m[4'(c)][4'(k)] & m[4'(c)][4'(k+1)]) |
                   (m[4'(c)][4'(k)] & m[4'(c)][4'(k+2)]) |
                   (m[4'(c)][4'(k+1)] & m[4'(c)][4'(k+2)]);
              k  = k + 3;
            end
            nm[4'(c)][4'(nh[4'(c)])] = s;
            nh[4'(c)] = nh[4'(c)] + 1;
            if (c < 15) begin
              nm[4'(c+1)][4'(nh[4'(c+1)])] = cy;
              nh[4'(c+1)] = nh[4'(c+1)] + 1;
            end
          end
        end
        // untouched bits pass straight through to the next stage
        for (int t = 0; t < 16; t++)
          if (t >= k && t < h[4'(c)]) begin
            nm[4'(c)][4'(nh[4'(c)])] = m[4'(c)][4'(t)];
            nh[4'(c)] = nh[4'(c)] + 1;
          end
      end
      m = nm;
      for (int c = 0; c < 16; c++) h[4'(c)] = nh[4'(c)];
    end
    for (int c = 0; c < 16; c++) begin
      row0[4'(c)] = m[4'(c)][0];
      row1[4'(c)] = m[4'(c)][1];
    end
  end

  assign y_o = row0 + row1;
endmodule

module dadda_mul_arbiter #(parameter int NREQ = 4) (
  input  logic              clk,
  input  logic              rst_n,
  dadda_mul_arbiter_if.slave bus
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;
  state_e state_q, state_d;

  logic [7:0]      a_q, b_q;
  logic [ID_W-1:0] id_q, last_q, gnt;
  logic            any_req, accept;
  logic [15:0]     y, resp_y_q;
  logic [ID_W-1:0] resp_id_q;
  logic            resp_valid_q;
  logic [NREQ-1:0] ready;

  dadda_8 u_mul (.a_i(a_q), .b_i(b_q), .y_o(y));

  // Round-robin pick: first valid requester after last_q, wrapping.
  always_comb begin
    int idx;
    gnt = '0;
    any_req = 1'b0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!any_req && bus.req_valid[ID_W'(idx)]) begin
        any_req = 1'b1;
        gnt = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        accept  = 1'b1;
        state_d = MUL;
      end
      MUL:  state_d = HOLD;
      HOLD: if (bus.resp_ready) begin
`ifdef MUL_ARB_BYPASS_EN
        if (any_req) begin
          accept  = 1'b1;
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    ready = accept ? (NREQ'(1) << gnt) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      last_q       <= ID_W'(NREQ - 1);   // requester 0 wins first
      resp_y_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= bus.req_a[gnt];
        b_q    <= bus.req_b[gnt];
        id_q   <= gnt;
        last_q <= gnt;
      end
      if (state_q == MUL) begin
        resp_y_q     <= y;
        resp_id_q    <= id_q;
        resp_valid_q <= 1'b1;
      end else if (state_q == HOLD && bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = resp_y_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Bench for dadda_mul_arbiter: transaction-level model (outstanding op, response
// due cycle, round-robin pointer) checked every cycle, plus directed scenarios.
module tb_dadda_mul_arbiter;
  localparam int NREQ = 4;
`ifdef MUL_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int GAP = BYP ? 2 : 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dadda_mul_arbiter_if #(.NREQ(NREQ)) bus();
  dadda_mul_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  bit          m_out  = 1'b0;
  int          m_rdy  = 0;
  logic [15:0] m_y    = '0;
  int          m_id   = 0;
  int          m_last = NREQ - 1;
  int          acc_id [$];
  int          acc_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[2'((last + k) % NREQ)]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Cycle-level compare against the transaction model.
  always @(negedge clk) begin
    bit e_rv, e_gr;
    int g;
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_y", bus.resp_y, 0);
      chk("rst_resp_id", bus.resp_id, 0);
      chk("rst_busy", bus.busy, 0);
      m_out  = 1'b0;
      m_last = NREQ - 1;
    end else begin
      e_rv = m_out && (cyc >= m_rdy);
      g    = rr_pick(bus.req_valid, m_last);
      e_gr = (g >= 0) && (!m_out || (BYP && e_rv && bus.resp_ready));
      chk("req_ready", bus.req_ready, e_gr ? (32'd1 << g) : 32'd0);
      chk("resp_valid", bus.resp_valid, e_rv);
      chk("busy", bus.busy, m_out);
      if (e_rv) begin
        chk("resp_y", bus.resp_y, m_y);
        chk("resp_id", bus.resp_id, m_id);
      end
      if (e_rv && bus.resp_ready) m_out = 1'b0;
      if (e_gr) begin
        m_out  = 1'b1;
        m_rdy  = cyc + 2;
        m_y    = 16'(bus.req_a[2'(g)]) * 16'(bus.req_b[2'(g)]);
        m_id   = g;
        m_last = g;
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.req_ready[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[2'(id)] = v;
    bus.req_a[2'(id)]     = a;
    bus.req_b[2'(id)]     = b;
  endtask

  task automatic wait_accept(input int id, output int c0);
    c0 = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready[2'(id)]) begin
        c0 = cyc;
        return;
      end
    end
    chk("accept_timeout", 32'(id), 32'hFFFF);
  endtask

  task automatic wait_resp(output int c1);
    c1 = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid) begin
        c1 = cyc;
        return;
      end
    end
    chk("resp_timeout", 0, 1);
  endtask

  task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] ey);
    int c0, c1;
    tick();
    set_req(id, 1'b1, a, b);
    wait_accept(id, c0);
    tick();
    set_req(id, 1'b0, 8'h00, 8'h00);
    wait_resp(c1);
    chk("latency", c1 - c0, 2);
    chk("lit_y", bus.resp_y, ey);
    chk("lit_id", bus.resp_id, id);
  endtask

  task automatic wait_n_acc(input int n);
    for (int t = 0; t < 60 && acc_id.size() < n; t++) begin
      @(negedge clk);
      #1;
    end
    chk("acc_count", acc_id.size() >= n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, c1;
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_bp[4] = '{2, 3, 2, 3};
    rst_n = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {bus.req_ready, bus.resp_valid, bus.resp_y, bus.resp_id, bus.busy}, 0);
    rst_n = 1'b1;

    // basic product / latency, then operand corners (leaves last grant = 3)
    run_one(0, 8'hFF, 8'hFF, 16'hFE01);
    run_one(1, 8'hAB, 8'h01, 16'h00AB);
    run_one(2, 8'h00, 8'hC3, 16'h0000);
    run_one(3, 8'h80, 8'h02, 16'h0100);

    // round-robin rotation with everyone requesting
    tick();
    base = acc_id.size();
    set_req(0, 1'b1, 8'h12, 8'h34);
    set_req(1, 1'b1, 8'h56, 8'h07);
    set_req(2, 1'b1, 8'h9A, 8'hBC);
    set_req(3, 1'b1, 8'hDE, 8'hF0);
    wait_n_acc(base + 5);
    tick();
    bus.req_valid = '0;
    if (acc_id.size() >= base + 5)
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", acc_id[base + i], exp_rr[i]);
        if (i > 0) chk("rr_gap", acc_cyc[base + i] - acc_cyc[base + i - 1], GAP);
      end
    repeat (6) tick();

    // throughput with req2/req3 always valid (last grant = 0)
    base = acc_id.size();
    set_req(2, 1'b1, 8'h0F, 8'h11);
    set_req(3, 1'b1, 8'h22, 8'h33);
    wait_n_acc(base + 4);
    tick();
    bus.req_valid = '0;
    if (acc_id.size() >= base + 4)
      for (int i = 0; i < 4; i++) begin
        chk("bp_order", acc_id[base + i], exp_bp[i]);
        if (i > 0) chk("bp_gap", acc_cyc[base + i] - acc_cyc[base + i - 1], GAP);
      end
    repeat (6) tick();

    // backpressure: response held, req1 waits (last grant = 3, so req0 first)
    bus.resp_ready = 1'b0;
    set_req(0, 1'b1, 8'h03, 8'h05);
    set_req(1, 1'b1, 8'h07, 8'h09);
    wait_accept(0, c0);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00);
    wait_resp(c1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_y", bus.resp_y, 16'd15);
      chk("hold_id", bus.resp_id, 0);
      chk("hold_ready", bus.req_ready, 0);
    end
    tick();
    bus.resp_ready = 1'b1;
    wait_accept(1, c0);
    tick();
    set_req(1, 1'b0, 8'h00, 8'h00);
    wait_resp(c1);
    chk("bp_req1_y", bus.resp_y, 16'd63);
    chk("bp_req1_id", bus.resp_id, 1);

    // reset while in MUL: no response, pointer back to req0
    tick();
    set_req(2, 1'b1, 8'h11, 8'h11);
    wait_accept(2, c0);
    tick();
    rst_n = 1'b0;
    set_req(2, 1'b0, 8'h00, 8'h00);
    #1;
    chk("midrst_outs", {bus.req_ready, bus.resp_valid, bus.resp_y, bus.resp_id, bus.busy}, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_no_resp", bus.resp_valid, 0);
    base = acc_id.size();
    set_req(0, 1'b1, 8'h02, 8'h03);
    set_req(3, 1'b1, 8'h04, 8'h05);
    wait_accept(0, c0);
    chk("midrst_first", (acc_id.size() > base) ? acc_id[base] : -1, 0);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00);
    wait_resp(c1);
    chk("midrst_y0", bus.resp_y, 16'd6);
    wait_accept(3, c0);
    tick();
    set_req(3, 1'b0, 8'h00, 8'h00);
    wait_resp(c1);
    chk("midrst_y3", bus.resp_y, 16'd20);
    chk("midrst_id3", bus.resp_id, 3);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
